// File: rtl/sift_rot_coord_gen.sv
// Streaming rotated-coordinate generator for the SIFT descriptor path.
// Latches one cos/sin pair on start, scans a WIN x WIN window in raster
// order and emits rounded, saturated (u, v) per sample on a valid/ready
// stream through a two-stage pipeline (products, then sum/round/saturate).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; coefficients and counters loaded on it
// S_SCAN  | issuing (r, c) into the pipeline on every advance
// S_DRAIN | all samples issued; waiting for the last beat to be taken
// S_DONE  | one-cycle done pulse, then back to idle
module sift_rot_coord_gen #(
  parameter int WIN  = 16,
  parameter int CW   = 9,
  parameter int FRAC = 7,
  parameter int OW   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CW-1:0]            cos_in,
  input  logic [CW-1:0]            sin_in,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_u,
  output logic [OW-1:0]            out_v,
  output logic [$clog2(WIN)-1:0]   out_row,
  output logic [$clog2(WIN)-1:0]   out_col,
  output logic                     out_last
);

  localparam int RW = $clog2(WIN);
  localparam int DW = RW + 2;        // signed half-sample offset width
  localparam int PW = DW + CW;       // full product width
  localparam int SW = PW + 2;        // sum of two products plus rounding
  localparam int SH = FRAC + 1;      // drop FRAC bits and the half-sample unit

  localparam logic signed [SW-1:0] RND  = SW'(2 ** FRAC);
  localparam logic signed [SW-1:0] MAXO = SW'(2 ** (OW - 1) - 1);
  localparam logic signed [SW-1:0] MINO = SW'(-(2 ** (OW - 1)));
  localparam logic [RW-1:0]        LAST = RW'(WIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [RW-1:0]        row_cnt, col_cnt;
  logic signed [CW-1:0] cos_q, sin_q;

  logic advance, issue, scan_end;

  logic signed [DW-1:0] dx, dy;
  logic signed [PW-1:0] dx_w, dy_w, cos_w, sin_w;

  logic                 s1_valid, s1_last;
  logic [RW-1:0]        s1_row, s1_col;
  logic signed [PW-1:0] p_xc, p_ys, p_yc, p_xs;

  logic signed [SW-1:0] u_sum, v_sum, u_sh, v_sh;
  logic [OW-1:0]        u_sat, v_sat;

  assign advance  = !out_valid || out_ready;
  assign issue    = (state == S_SCAN) && advance;
  assign scan_end = (row_cnt == LAST) && (col_cnt == LAST);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  assign dx    = $signed({1'b0, col_cnt, 1'b0}) - $signed(DW'(WIN - 1));
  assign dy    = $signed({1'b0, row_cnt, 1'b0}) - $signed(DW'(WIN - 1));
  assign dx_w  = {{(PW - DW){dx[DW-1]}}, dx};
  assign dy_w  = {{(PW - DW){dy[DW-1]}}, dy};
  assign cos_w = {{(PW - CW){cos_q[CW-1]}}, cos_q};
  assign sin_w = {{(PW - CW){sin_q[CW-1]}}, sin_q};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; the last beat's acceptance is what ends the drain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (issue && scan_end) state_nxt = S_DRAIN;
      S_DRAIN: if (out_valid && out_ready && out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Coefficient latch and raster counters; counters move only when a sample issues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_q   <= '0;
      sin_q   <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      cos_q   <= cos_in;
      sin_q   <= sin_in;
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (issue) begin
      col_cnt <= col_cnt + 1'b1;
      if (col_cnt == LAST) row_cnt <= row_cnt + 1'b1;
    end
  end

  // Stage-2 combinational: full-precision sum, round half up, shift, saturate.
  always_comb begin
    u_sum = {{2{p_xc[PW-1]}}, p_xc} + {{2{p_ys[PW-1]}}, p_ys} + RND;
    v_sum = {{2{p_yc[PW-1]}}, p_yc} - {{2{p_xs[PW-1]}}, p_xs} + RND;
    u_sh  = u_sum >>> SH;
    v_sh  = v_sum >>> SH;
    u_sat = u_sh[OW-1:0];
    v_sat = v_sh[OW-1:0];
    if (u_sh > MAXO) u_sat = MAXO[OW-1:0];
    else if (u_sh < MINO) u_sat = MINO[OW-1:0];
    if (v_sh > MAXO) v_sat = MAXO[OW-1:0];
    else if (v_sh < MINO) v_sat = MINO[OW-1:0];
  end

  // Both pipeline stages move together on advance, so a stall freezes every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      p_xc      <= '0;
      p_ys      <= '0;
      p_yc      <= '0;
      p_xs      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_u     <= '0;
      out_v     <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (advance) begin
      s1_valid  <= issue;
      s1_last   <= issue && scan_end;
      s1_row    <= row_cnt;
      s1_col    <= col_cnt;
      p_xc      <= dx_w * cos_w;
      p_ys      <= dy_w * sin_w;
      p_yc      <= dy_w * cos_w;
      p_xs      <= dx_w * sin_w;
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_u   <= u_sat;
        out_v   <= v_sat;
        out_row <= s1_row;
        out_col <= s1_col;
      end
    end
  end

endmodule
